// File: rtl/pixel_row_shifter.sv
// Shifts one HUB75 display row: fetches each column's pixel pair, reduces it to the active bitplane, clocks it out.
// Per column LOAD_WAIT+3 cycles, all outputs registered; row_start is ignored unless idle and armed after reset.
module pixel_row_shifter #(
  parameter int PIXEL_COLUMNS   = 64,
  parameter int LOAD_WAIT       = 4,
  parameter int BRIGHTNESS_BITS = 6
) (
  input  logic                       clk_in,
  input  logic                       reset,
  input  logic                       row_start,
  input  logic [BRIGHTNESS_BITS-1:0] brightness_mask,
  input  logic [15:0]                rgb565_top,
  input  logic [15:0]                rgb565_bottom,
  output logic [5:0]                 column_address,
  output logic                       pixel_load_start,
  output logic [2:0]                 rgb1,
  output logic [2:0]                 rgb2,
  output logic                       pixel_clock,
  output logic                       row_busy,
  output logic                       row_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DATA,
    S_CLK_HI,
    S_DONE
  } state_t;

  localparam logic [5:0] LAST_COL = 6'(PIXEL_COLUMNS - 1);
  localparam logic [3:0] WAIT_LD  = 4'(LOAD_WAIT);

  state_t                     r_state, w_state;
  logic [5:0]                 r_col, w_col;
  logic [3:0]                 r_wait_cnt, w_wait_cnt;
  logic [BRIGHTNESS_BITS-1:0] r_mask, w_mask;
  logic [2:0]                 r_rgb1, w_rgb1;
  logic [2:0]                 r_rgb2, w_rgb2;
  logic                       r_pls, w_pls;
  logic                       r_pclk, w_pclk;
  logic                       r_busy, w_busy;
  logic                       r_done, w_done;
  logic                       r_armed;

  // Expand RGB565 to 6-bit channels (5-bit R/B replicate their MSB) and pick the plane bit.
  function automatic logic [2:0] plane_bits(input logic [15:0] w, input logic [BRIGHTNESS_BITS-1:0] m);
    logic [5:0] r6, g6, b6;
    r6 = {w[15:11], w[15]};
    g6 = w[10:5];
    b6 = {w[4:0], w[4]};
    return {|(r6 & m), |(g6 & m), |(b6 & m)};
  endfunction

  always_comb begin
    w_state    = r_state;
    w_col      = r_col;
    w_wait_cnt = r_wait_cnt;
    w_mask     = r_mask;
    w_rgb1     = r_rgb1;
    w_rgb2     = r_rgb2;
    case (r_state)
      S_IDLE: begin
        if (row_start && r_armed) begin
          w_mask  = brightness_mask;
          w_col   = 6'd0;
          w_state = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_wait_cnt = WAIT_LD;
        w_state    = S_WAIT;
      end
      S_WAIT: begin
        w_wait_cnt = r_wait_cnt - 4'd1;
        if (r_wait_cnt <= 4'd1) w_state = S_DATA;
      end
      S_DATA:   w_state = S_CLK_HI;
      S_CLK_HI: begin
        if (r_col == LAST_COL) begin
          w_state = S_DONE;
        end else begin
          w_col   = r_col + 6'd1;
          w_state = S_ISSUE;
        end
      end
      S_DONE:   w_state = S_IDLE;
      default:  w_state = S_IDLE;
    endcase

    // Outputs are decoded from the next state so each one is a flop aligned with its state.
    w_pls  = (w_state == S_ISSUE);
    w_pclk = (w_state == S_CLK_HI);
    w_busy = (w_state != S_IDLE);
    w_done = (w_state == S_DONE);
    if (w_state == S_DATA) begin
      w_rgb1 = plane_bits(rgb565_top, r_mask);
      w_rgb2 = plane_bits(rgb565_bottom, r_mask);
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_col      <= 6'd0;
      r_wait_cnt <= 4'd0;
      r_mask     <= '0;
      r_rgb1     <= 3'd0;
      r_rgb2     <= 3'd0;
      r_pls      <= 1'b0;
      r_pclk     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_armed    <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_col      <= w_col;
      r_wait_cnt <= w_wait_cnt;
      r_mask     <= w_mask;
      r_rgb1     <= w_rgb1;
      r_rgb2     <= w_rgb2;
      r_pls      <= w_pls;
      r_pclk     <= w_pclk;
      r_busy     <= w_busy;
      r_done     <= w_done;
      r_armed    <= 1'b1;
    end
  end

  assign column_address   = r_col;
  assign pixel_load_start = r_pls;
  assign rgb1             = r_rgb1;
  assign rgb2             = r_rgb2;
  assign pixel_clock      = r_pclk;
  assign row_busy         = r_busy;
  assign row_done         = r_done;

endmodule

// File: doc/pixel_row_shifter.md
Name: pixel_row_shifter

Overview:
Downstream consumer of framebuffer_fetch. For one display row, it walks the column address, requests each pixel pair, and latches the returned top and bottom RGB565 words. It then reduces each word to one bit per colour for the active brightness plane and drives the HUB75 rgb1/rgb2 lines and the pixel shift clock. It signals completion so the row/latch/OE sequencer can latch the row and advance.

Parameters:
PIXEL_COLUMNS, 64, columns shifted per row; column_address counts 0..PIXEL_COLUMNS-1.
LOAD_WAIT, 4, clk_in cycles between the pixel_load_start pulse and rgb565_top/bottom being valid. Legal range is 1..15; the system uses 4, or 3 with USE_FM6126A.
BRIGHTNESS_BITS, 6, width of the expanded colour channels and of brightness_mask.

Ports:
clk_in  input  1  system clock; all logic on posedge.
reset  input  1  asynchronous, active-low reset.
row_start  input  1  single-cycle request to shift one row; honoured only in IDLE.
brightness_mask  input  BRIGHTNESS_BITS  one-hot bitplane select; sampled on the accepted row_start.
rgb565_top  input  16  top-half pixel from framebuffer_fetch.
rgb565_bottom  input  16  bottom-half pixel from framebuffer_fetch.
column_address  output  6  column being fetched or shifted (to framebuffer_fetch).
pixel_load_start  output  1  one-cycle fetch request (to framebuffer_fetch).
rgb1  output  3  {R,G,B} plane bits, top half.
rgb2  output  3  {R,G,B} plane bits, bottom half.
pixel_clock  output  1  HUB75 shift clock; panel samples on its rising edge.
row_busy  output  1  high while a row is in progress.
row_done  output  1  one-cycle pulse after the last column's clock-high cycle.

Behaviour:
- Reset (reset=0, async): state=IDLE; column_address=0, pixel_load_start=0, rgb1=0, rgb2=0, pixel_clock=0, row_busy=0, row_done=0; latched mask=0; wait counter=0. Assertion mid-row aborts immediately. No row_done is issued for an aborted row.
- All outputs are registered.
- State IDLE: row_busy=0. When row_start=1, latch brightness_mask, set column=0 and go to ISSUE.
- State ISSUE (1 cycle): pixel_load_start=1, column_address=col, row_busy=1, pixel_clock=0. Load the wait counter with LOAD_WAIT and go to WAIT.
- State WAIT: pixel_load_start=0. Decrement the counter each cycle. When the counter reaches 1, go to DATA. WAIT therefore lasts exactly LOAD_WAIT cycles.
- State DATA (1 cycle): register rgb1/rgb2 from the current rgb565 inputs; pixel_clock=0. Go to CLK_HI.
- State CLK_HI (1 cycle): pixel_clock=1; rgb1/rgb2 held.
  - If col==PIXEL_COLUMNS-1, go to DONE.
  - Otherwise col<=col+1 and go to ISSUE.
- State DONE (1 cycle): row_done=1, row_busy=1, pixel_clock=0. Go to IDLE.
- Per-column period is LOAD_WAIT+3 cycles. A row takes PIXEL_COLUMNS*(LOAD_WAIT+3)+1 cycles from ISSUE of column 0 through DONE.
- column_address is stable from ISSUE through CLK_HI of the same column. It changes only on the CLK_HI->ISSUE transition. No wrap is needed beyond 63, since DONE terminates the row.
- rgb1/rgb2 are stable for the whole DATA->CLK_HI window (setup ≥1 cycle before the pixel_clock rise). They are held through DONE and IDLE until the next DATA.
- Channel expansion from RGB565 word w:
  - R6 = {w[15:11], w[15]}
  - G6 = w[10:5]
  - B6 = {w[4:0], w[4]}
- Plane bit for each channel = |(C6 & mask). rgb = {Rbit, Gbit, Bbit}.
- Mask edge cases:
  - mask=0: all plane bits 0.
  - multi-hot mask: bits ORed, defined but not used in system.
- Changes on brightness_mask during a row are ignored.
- row_start while not IDLE, including the DONE cycle: ignored and not queued.
- row_start in the same cycle as reset release: ignored; reset dominates.

Test Plan:
- Reset value check: hold reset=0 mid-row (column 10, WAIT) → all outputs 0 next sample, state IDLE. After release, no row_done appears within 1000 cycles.
- Basic row, LOAD_WAIT=4: one row_start → exactly 64 pixel_load_start pulses and 64 pixel_clock rising edges. column_address sequence is 0..63. row_done is asserted 449 cycles after the ISSUE of column 0 (inclusive count). row_busy falls the cycle after row_done.
- Plane extraction: rgb565_top=16'hF800, bottom=16'h07E0, mask=6'b100000 → rgb1=3'b100, rgb2=3'b010. Same data with mask=6'b000001 → rgb1=3'b100 (R replicated LSB), rgb2=3'b010.
- Fetch alignment: model framebuffer_fetch returning data=column index in blue bits exactly LOAD_WAIT cycles after the pulse. The bench samples rgb on each pixel_clock rise; the stream must match columns 0..63 with no skew, for LOAD_WAIT=3 and LOAD_WAIT=4.
- Handshake robustness: row_start pulsed at column 20 and during DONE → no restart and still exactly 64 clocks. brightness_mask changed mid-row from 6'b000100 to 6'b001000 → all columns use 6'b000100.
- Zero mask: mask=0 with rgb565=16'hFFFF → rgb1=rgb2=3'b000 for all 64 clocks.
